// File: rtl/mcdf_pkg.sv
// Shared definitions for the MCDF formatter receive path: receiver FSM
// states, error codes, the legal packet lengths and the channel count.
package mcdf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRANT      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_RECV       = 3'd3,
        ST_DRAIN      = 3'd4
    } rx_state_e;

    localparam logic [1:0] ERR_SHORT   = 2'd0;
    localparam logic [1:0] ERR_LONG    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_BAD_LEN = 2'd3;

    localparam logic [5:0] LEN_4  = 6'd4;
    localparam logic [5:0] LEN_8  = 6'd8;
    localparam logic [5:0] LEN_16 = 6'd16;
    localparam logic [5:0] LEN_32 = 6'd32;

    localparam int NUM_CH = 4;

    // True for the four packet lengths the formatter is allowed to advertise.
    function automatic logic is_legal_len(input logic [5:0] len);
        logic legal;
        case (len)
            LEN_4, LEN_8, LEN_16, LEN_32: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/fmt_rx_cnt.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module fmt_rx_cnt
    import mcdf_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step on enable unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fmt_rx.sv
// Formatter-side packet receiver: grants one packet at a time, checks its
// framing against the advertised length, re-emits the words as a registered
// stream with channel/sop/eop tags and keeps good-packet and error counters.
// The formatter never stalls once a packet has started: every RECV cycle
// carries exactly one word.
module fmt_rx
    import mcdf_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fmt_req_i,
    input  logic [1:0]       fmt_chid_i,
    input  logic [5:0]       fmt_length_i,
    output logic             fmt_grant_o,
    input  logic [31:0]      fmt_data_i,
    input  logic             fmt_start_i,
    input  logic             fmt_end_i,
    input  logic             rx_ready_i,
    output logic             rx_valid_o,
    output logic [31:0]      rx_data_o,
    output logic [1:0]       rx_chid_o,
    output logic             rx_sop_o,
    output logic             rx_eop_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    input  logic [1:0]       cnt_sel_i,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int             TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

    rx_state_e     state_q,    state_d;
    logic [1:0]    chid_q,     chid_d;
    logic [5:0]    len_q,      len_d;
    logic          bad_len_q,  bad_len_d;
    logic [5:0]    count_q,    count_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic          grant_q,    grant_d;
    logic          valid_q,    valid_d;
    logic [31:0]   data_q,     data_d;
    logic [1:0]    out_chid_q, out_chid_d;
    logic          sop_q,      sop_d;
    logic          eop_q,      eop_d;
    logic          err_q,      err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          good_q,     good_d;

    logic          accept;
    logic [6:0]    word_n;
    logic          len_hit;

    // 7-bit compare so an illegal length of 0 or above 32 never matches early.
    assign word_n  = {1'b0, count_q} + 7'd1;
    assign len_hit = (word_n == {1'b0, len_q});

    // Next-state and registered-output logic of the receive FSM.
    always_comb begin
        state_d    = state_q;
        chid_d     = chid_q;
        len_d      = len_q;
        bad_len_d  = bad_len_q;
        count_d    = count_q;
        timer_d    = timer_q;
        grant_d    = 1'b0;
        valid_d    = 1'b0;
        data_d     = '0;
        out_chid_d = '0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        err_code_d = '0;
        good_d     = 1'b0;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fmt_req_i && rx_ready_i) begin
                    chid_d  = fmt_chid_i;
                    len_d   = fmt_length_i;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                grant_d   = 1'b1;
                count_d   = '0;
                timer_d   = '0;
                bad_len_d = !is_legal_len(len_q);
                if (!is_legal_len(len_q)) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BAD_LEN;
                end
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (fmt_start_i) begin
                    accept = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RECV: begin
                accept = 1'b1;
            end
            ST_DRAIN: begin
                timer_d = timer_q + TW'(1);
                if (fmt_end_i || (timer_q == TIMER_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One packet word: forward it and decide how the packet terminates.
        // In WAIT_START count_q is 0, so word_n is 1 for the start word.
        if (accept) begin
            valid_d    = 1'b1;
            data_d     = fmt_data_i;
            out_chid_d = chid_q;
            sop_d      = (state_q == ST_WAIT_START);
            count_d    = (count_q == 6'h3F) ? count_q : count_q + 6'd1;
            state_d    = ST_RECV;
            if (fmt_end_i) begin
                eop_d   = 1'b1;
                state_d = ST_IDLE;
                if ((state_q == ST_RECV) && len_hit) begin
                    good_d = !bad_len_q;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_SHORT;
                end
            end else if (len_hit) begin
                eop_d      = 1'b1;
                err_d      = 1'b1;
                err_code_d = ERR_LONG;
                timer_d    = '0;
                state_d    = ST_DRAIN;
            end
        end
    end

    // State, packet context and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            chid_q     <= '0;
            len_q      <= '0;
            bad_len_q  <= 1'b0;
            count_q    <= '0;
            timer_q    <= '0;
            grant_q    <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            out_chid_q <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            good_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chid_q     <= chid_d;
            len_q      <= len_d;
            bad_len_q  <= bad_len_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            out_chid_q <= out_chid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            good_q     <= good_d;
        end
    end

    assign fmt_grant_o = grant_q;
    assign rx_valid_o  = valid_q;
    assign rx_data_o   = data_q;
    assign rx_chid_o   = out_chid_q;
    assign rx_sop_o    = sop_q;
    assign rx_eop_o    = eop_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

    // Per-channel good-packet counters. chid_q still names the finished
    // packet in the cycle good_q is high, since a new request can only
    // overwrite it on the following edge.
    logic [CNT_W-1:0] ch_cnt [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_cnt
        fmt_rx_cnt #(.W(CNT_W)) u_ch_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (good_q && (chid_q == 2'(g))),
            .cnt_o (ch_cnt[g])
        );
    end

    fmt_rx_cnt #(.W(CNT_W)) u_err_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (err_q),
        .cnt_o (err_cnt_o)
    );

    assign pkt_cnt_o = ch_cnt[cnt_sel_i];

endmodule

// File: tb/tb_fmt_rx.sv
// Bench for fmt_rx: directed scenarios plus randomized packets, checked
// against a packet-level model (expected word stream, error codes, counts).
module tb_fmt_rx;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;
  localparam int W       = 36;  // {chid, sop, eop, data}

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             fmt_req_i;
  logic [1:0]       fmt_chid_i;
  logic [5:0]       fmt_length_i;
  logic             fmt_grant_o;
  logic [31:0]      fmt_data_i;
  logic             fmt_start_i;
  logic             fmt_end_i;
  logic             rx_ready_i;
  logic             rx_valid_o;
  logic [31:0]      rx_data_o;
  logic [1:0]       rx_chid_o;
  logic             rx_sop_o;
  logic             rx_eop_o;
  logic             err_o;
  logic [1:0]       err_code_o;
  logic [1:0]       cnt_sel_i;
  logic [CNT_W-1:0] pkt_cnt_o;
  logic [CNT_W-1:0] err_cnt_o;

  fmt_rx #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fmt_req_i(fmt_req_i), .fmt_chid_i(fmt_chid_i),
    .fmt_length_i(fmt_length_i), .fmt_grant_o(fmt_grant_o), .fmt_data_i(fmt_data_i),
    .fmt_start_i(fmt_start_i), .fmt_end_i(fmt_end_i), .rx_ready_i(rx_ready_i),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_chid_o(rx_chid_o),
    .rx_sop_o(rx_sop_o), .rx_eop_o(rx_eop_o), .err_o(err_o), .err_code_o(err_code_o),
    .cnt_sel_i(cnt_sel_i), .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_err_q[$];
  int           pkt_model[4];
  int           err_model;
  int           grant_seen;
  logic         prev_grant;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (rx_valid_o === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_word", 1, 0);
      else check("word", {rx_chid_o, rx_sop_o, rx_eop_o, rx_data_o}, exp_q.pop_front());
    end
    if (err_o === 1'b1) begin
      if (exp_err_q.size() == 0) check("unexpected_err", {62'd0, err_code_o}, 64'hFF);
      else check("err_code", err_code_o, exp_err_q.pop_front());
      if (err_code_o == 2'd0 || err_code_o == 2'd1) check("err_eop_align", rx_eop_o, 1);
    end
    if (fmt_grant_o === 1'b1) begin
      grant_seen++;
      if (prev_grant) check("grant_pulse_width", 2, 1);
    end
    prev_grant = (fmt_grant_o === 1'b1);
  end

  // ---------------- reference model ----------------
  function automatic bit legal_len(input int len);
    return (len == 4) || (len == 8) || (len == 16) || (len == 32);
  endfunction

  // Packet of len advertised words; end marker rides on word index e.
  // Output stops at the end marker or at the advertised length, whichever
  // comes first; the packet is good only if both coincide (and e > 0).
  function automatic void model_expect(input int ch, input int len, input int e,
                                       input logic [31:0] base, input logic [31:0] step);
    int last;
    last = (e + 1 <= len) ? e : len - 1;
    for (int i = 0; i <= last; i++)
      exp_q.push_back({2'(ch), (i == 0), (i == last), base + step * i});
    if (!legal_len(len)) begin
      exp_err_q.push_back(2'd3);
      err_model++;
    end
    if (e == last && e + 1 == len && e != 0) begin
      if (legal_len(len)) pkt_model[ch]++;
    end else begin
      exp_err_q.push_back((e == last) ? 2'd0 : 2'd1);
      err_model++;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic request(input logic [1:0] ch, input logic [5:0] len, output bit ok);
    int lat;
    fmt_chid_i = ch;
    fmt_length_i = len;
    fmt_req_i = 1'b1;
    ok = 0;
    lat = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      lat++;
      if (fmt_grant_o) ok = 1;
    end
    fmt_req_i = 1'b0;
    check("grant_latency", ok ? lat : 99, 2);
  endtask

  task automatic send_packet(input int ch, input int len, input int e, input int resp,
                             input logic [31:0] base, input logic [31:0] step);
    bit ok;
    request(2'(ch), 6'(len), ok);
    if (ok) begin
      model_expect(ch, len, e, base, step);
      repeat (resp) tick();
      for (int i = 0; i <= e; i++) begin
        fmt_data_i = base + step * i;
        fmt_start_i = (i == 0);
        fmt_end_i = (i == e);
        tick();
      end
      fmt_start_i = 1'b0;
      fmt_end_i = 1'b0;
      fmt_data_i = '0;
    end
  endtask

  task automatic check_counters();
    repeat (2) tick();
    for (int c = 0; c < 4; c++) begin
      cnt_sel_i = 2'(c);
      #1;
      check($sformatf("pkt_cnt_ch%0d", c), pkt_cnt_o, pkt_model[c]);
    end
    check("err_cnt", err_cnt_o, err_model);
    check("exp_words_left", exp_q.size(), 0);
    check("exp_errs_left", exp_err_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    int lat, g0, len, e;
    rst_i = 1'b1; fmt_req_i = 0; fmt_chid_i = 0; fmt_length_i = 0;
    fmt_data_i = 0; fmt_start_i = 0; fmt_end_i = 0; rx_ready_i = 1; cnt_sel_i = 0;
    grant_seen = 0; prev_grant = 0; err_model = 0;
    for (int c = 0; c < 4; c++) pkt_model[c] = 0;
    repeat (3) tick();
    check("rst_outputs", {fmt_grant_o, rx_valid_o, rx_sop_o, rx_eop_o, err_o, err_code_o,
                          rx_chid_o, rx_data_o}, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    rst_i = 1'b0;
    tick();

    // ch0 length 32, data 10..320, start answered one cycle after grant
    send_packet(0, 32, 31, 1, 32'd10, 32'd10);
    check_counters();

    // back-to-back ch1 len 16 then ch2 len 8
    send_packet(1, 16, 15, 0, 32'd11, 32'd10);
    send_packet(2, 8, 7, 0, 32'd12, 32'd10);
    check_counters();

    // ch2 len 8, end on word 5 -> short
    send_packet(2, 8, 4, 0, 32'h100, 32'd1);
    check_counters();

    // timeout: grant with no start
    request(2'd0, 6'd4, ok);
    if (ok) begin
      exp_err_q.push_back(2'd2);
      err_model++;
      lat = 99;
      for (int i = 1; i <= 40 && lat == 99; i++) begin
        tick();
        if (err_o) lat = i;
      end
      check("timeout_latency_ok", (lat >= TIMEOUT - 1 && lat <= TIMEOUT + 1), 1);
    end
    check_counters();

    // length 4, end only on word 6 -> long, drain to end marker
    send_packet(3, 4, 5, 0, 32'h200, 32'd3);
    check_counters();

    // ready low holds off the grant
    rx_ready_i = 1'b0;
    fmt_chid_i = 2'd1; fmt_length_i = 6'd4; fmt_req_i = 1'b1;
    g0 = grant_seen;
    repeat (6) tick();
    check("no_grant_when_not_ready", grant_seen - g0, 0);
    rx_ready_i = 1'b1;
    send_packet(1, 4, 3, 0, 32'h300, 32'd1);
    check_counters();

    // reset on word 9 of a 16-word packet
    request(2'd3, 6'd16, ok);
    if (ok) begin
      for (int i = 0; i < 8; i++) exp_q.push_back({2'd3, (i == 0), 1'b0, 32'h400 + i});
      for (int i = 0; i < 9; i++) begin
        fmt_data_i = 32'h400 + i;
        fmt_start_i = (i == 0);
        rst_i = (i == 8);
        tick();
      end
      fmt_start_i = 0; fmt_data_i = 0;
      check("rst_mid_outputs", {fmt_grant_o, rx_valid_o, rx_sop_o, rx_eop_o, err_o, err_code_o,
                                rx_chid_o, rx_data_o}, 0);
      rst_i = 1'b0;
      for (int c = 0; c < 4; c++) pkt_model[c] = 0;
      err_model = 0;
    end
    check_counters();

    // illegal length 5: code 3 at grant, packet framed but not counted
    send_packet(0, 5, 4, 0, 32'h500, 32'd2);
    check_counters();

    // randomized packets
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0: len = 4;
        1: len = 8;
        2: len = 16;
        3: len = 32;
        4: len = 5;
        default: len = 12;
      endcase
      if ($urandom_range(0, 9) < 6) e = len - 1;
      else e = $urandom_range(0, len + 3);
      send_packet($urandom_range(0, 3), len, e, $urandom_range(0, 2), $urandom, $urandom);
      check_counters();
    end

    repeat (4) tick();
    check("final_words_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fmt_rx.md
# fmt_rx

Packet receiver for the formatter output interface of the MCDF. It sits downstream of `formatter`, on the far end of the `fmt_*` bus, and issues `fmt_grant`. It captures each granted packet and checks its framing against the advertised length. It re-emits the words as a registered stream tagged with channel and packet boundaries, and keeps per-channel good-packet counters.

## Interface
- `TIMEOUT`, default 16: maximum cycles from grant to `fmt_start_i` before the packet is abandoned.
- `CNT_W`, default 16: width of the packet and error counters.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `fmt_req_i`, in, 1: formatter requests to send a packet.
- `fmt_chid_i`, in, 2: channel id of the offered packet, valid while `fmt_req_i` is high.
- `fmt_length_i`, in, 6: packet length in words (4, 8, 16 or 32), valid while `fmt_req_i` is high.
- `fmt_grant_o`, out, 1: one-cycle grant pulse.
- `fmt_data_i`, in, 32: packet word.
- `fmt_start_i`, in, 1: marks the first word.
- `fmt_end_i`, in, 1: marks the last word.
- `rx_ready_i`, in, 1: downstream can absorb one full packet; gates grants only.
- `rx_valid_o`, out, 1: output word valid.
- `rx_data_o`, out, 32: output word.
- `rx_chid_o`, out, 2: channel of the current packet.
- `rx_sop_o`, out, 1: first word of a packet.
- `rx_eop_o`, out, 1: last word of a packet.
- `err_o`, out, 1: one-cycle error pulse.
- `err_code_o`, out, 2: error code, valid with `err_o`. 0 = short, 1 = long, 2 = timeout, 3 = bad length.
- `cnt_sel_i`, in, 2: channel select for `pkt_cnt_o`.
- `pkt_cnt_o`, out, CNT_W: good-packet count of the selected channel (combinational read).
- `err_cnt_o`, out, CNT_W: total error count.

## Operation
- FSM states: IDLE, GRANT, WAIT_START, RECV, DRAIN.
- IDLE: when `fmt_req_i` and `rx_ready_i` are both high, latch chid and length, then go to GRANT.
- GRANT: drive `fmt_grant_o` high for this cycle only, clear the word counter and timer, then go to WAIT_START.
  - If the latched length is not 4, 8, 16 or 32, pulse `err_o` with code 3. The packet is still received against the latched value.
- WAIT_START: the timer counts up each cycle.
  - When `fmt_start_i` is seen, output the word with sop, set count = 1, and go to RECV.
  - When the timer reaches `TIMEOUT` first, pulse code 2 and go to IDLE.
- RECV: every cycle is one word; the formatter does not stall.
  - Output the word and increment count.
  - If `fmt_end_i` arrives and count+1 == length: set eop, increment the channel's packet counter, go to IDLE.
  - If `fmt_end_i` arrives and count+1 < length: set eop, pulse code 0, go to IDLE.
  - If count+1 == length without `fmt_end_i`: set eop, pulse code 1, go to DRAIN.
  - `fmt_start_i` in RECV is ignored.
- DRAIN: discard words, with no `rx_valid_o`. Return to IDLE on `fmt_end_i` or on `TIMEOUT` cycles.
- `fmt_start_i` and `fmt_end_i` in the same cycle in WAIT_START count as a short packet: sop, eop and code 0 on the same output word.
- `rx_ready_i` falling mid-packet has no effect on the packet in flight.
- Counters: a packet is counted only if it had no error of any code. All counters saturate at all-ones. `err_cnt_o` increments on every `err_o`.
- Word counter is 6 bits and compared against the full 6-bit latched length (32 fits); it never wraps.

## Timing
- Reset: every output is 0, all counters are 0, the FSM is in IDLE. Reset mid-packet abandons the packet with no error pulse.
- Grant latency: `fmt_req_i` sampled high in IDLE gives `fmt_grant_o` high exactly 2 edges later (IDLE→GRANT, output registered), for 1 cycle.
- Data latency: a word sampled at edge N appears on `rx_*` after edge N+1, i.e. one register stage.
- `err_o` is aligned with the eop word for codes 0 and 1. It occurs 1 cycle after the triggering state for codes 2 and 3.
- After an eop in RECV the FSM is in IDLE, so the next grant can come 2 cycles after a back-to-back request.
- `pkt_cnt_o` reflects an increment on the cycle after the eop.

## Structure
- Shared package `mcdf_pkg` holds:
  - the FSM state enum;
  - error-code constants;
  - the length encodings 4/8/16/32 and a legal-length function;
  - the channel-count constant, 4.
- One sub-module, `fmt_rx_cnt`: a saturating CNT_W counter with enable, instantiated 4 times for the channels and once for errors.

## Test plan
- ch0, length 32, words 10, 20, …, 320 with start on 10 and end on 320, grant answered 1 cycle later → 32 `rx_valid_o` with matching data, sop on 10, eop on 320, `pkt_cnt_o[0]` = 1, no `err_o`.
- ch1, length 16 (11..161), then ch2, length 8 (12..82), back-to-back requests → two grants, each 2 cycles after its request; counters ch1 = 1 and ch2 = 1.
- ch2, length 8 but `fmt_end_i` on word 5 → eop on word 5, `err_o` with code 0, `err_cnt_o` = 1, ch2 counter unchanged.
- Grant issued but no `fmt_start_i` for 16 cycles → code 2 and return to IDLE. Then a length 4 with no end marker → eop on word 4, code 1, DRAIN until end.
- `rx_ready_i` = 0 with `fmt_req_i` held high → no grant; raising ready → grant 2 cycles later. `rst_i` asserted on word 9 of a 16-word packet → outputs 0 on the next cycle, no count and no error.
- Length 5 requested → code 3 at grant. Five words followed by end → eop, but no packet count increment.
